// File: rtl/spwm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : spwm_decoder
// Brief    : Measures high time and period of an asynchronous PWM input,
//            rising edge to rising edge, with stuck-high/low detection.
//            Optional macro SPWM_DECODER_AVG_EN replaces the raw outputs
//            with a 4-sample boxcar average of the last 4 measurements.
// Revision : 1.0 - initial release
// ============================================================================
module spwm_decoder #(
  parameter int CW          = 12,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4095
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          pwm_in,
  output logic [CW-1:0] duty,
  output logic [CW-1:0] period,
  output logic          valid,
  output logic          stuck_hi,
  output logic          stuck_lo
);

  localparam logic [CW-1:0] c_maxCnt  = '1;
  localparam logic [CW-1:0] c_timeout = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_pwmD;
  logic [CW-1:0]          r_hiCnt;
  logic [CW-1:0]          r_perCnt;
  logic [CW-1:0]          r_armCnt;

  logic                   w_pwmS;
  logic                   w_rise;
  logic                   w_fall;
  logic [CW-1:0]          w_hiNext;
  logic [CW-1:0]          w_perNext;
  logic [CW-1:0]          w_armNext;
  logic [CW-1:0]          w_outDuty;
  logic [CW-1:0]          w_outPer;
  logic                   w_outValid;

  assign w_pwmS = r_sync[SYNC_STAGES-1];
  assign w_rise = w_pwmS & ~r_pwmD;
  assign w_fall = ~w_pwmS & r_pwmD;

  // Saturating increments: counters stop at all-ones rather than wrapping.
  assign w_hiNext  = (r_hiCnt  == c_maxCnt) ? r_hiCnt  : r_hiCnt  + 1'b1;
  assign w_perNext = (r_perCnt == c_maxCnt) ? r_perCnt : r_perCnt + 1'b1;
  assign w_armNext = (r_armCnt == c_maxCnt) ? r_armCnt : r_armCnt + 1'b1;

  // Input synchroniser plus one-cycle delay for edge detection; keeps running while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_pwmD <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_pwmD <= w_pwmS;
    end
  end

`ifdef SPWM_DECODER_AVG_EN
  logic [CW-1:0] r_histDuty [3];
  logic [CW-1:0] r_histPer  [3];
  logic [1:0]    r_histCnt;
  logic [CW+1:0] w_sumDuty;
  logic [CW+1:0] w_sumPer;

  assign w_sumDuty = {2'b00, r_hiCnt}  + {2'b00, r_histDuty[0]}
                   + {2'b00, r_histDuty[1]} + {2'b00, r_histDuty[2]};
  assign w_sumPer  = {2'b00, r_perCnt} + {2'b00, r_histPer[0]}
                   + {2'b00, r_histPer[1]}  + {2'b00, r_histPer[2]};
  assign w_outDuty  = CW'(w_sumDuty >> 2);
  assign w_outPer   = CW'(w_sumPer >> 2);
  // The current measurement plus three stored ones make a full window.
  assign w_outValid = (r_histCnt == 2'd3);

  // History of the three previous raw measurements; emptied whenever the decoder is re-armed.
  always_ff @(posedge clk) begin
    if (rst || !en || r_state == ARM) begin
      for (int i = 0; i < 3; i++) begin
        r_histDuty[i] <= '0;
        r_histPer[i]  <= '0;
      end
      r_histCnt <= 2'd0;
    end else if (w_rise) begin
      r_histDuty[0] <= r_hiCnt;
      r_histDuty[1] <= r_histDuty[0];
      r_histDuty[2] <= r_histDuty[1];
      r_histPer[0]  <= r_perCnt;
      r_histPer[1]  <= r_histPer[0];
      r_histPer[2]  <= r_histPer[1];
      if (r_histCnt != 2'd3) begin
        r_histCnt <= r_histCnt + 2'd1;
      end
    end
  end
`else
  assign w_outDuty  = r_hiCnt;
  assign w_outPer   = r_perCnt;
  assign w_outValid = 1'b1;
`endif

  // Measurement state machine with registered duty/period/valid and stuck flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ARM;
      r_hiCnt  <= '0;
      r_perCnt <= '0;
      r_armCnt <= '0;
      duty     <= '0;
      period   <= '0;
      valid    <= 1'b0;
      stuck_hi <= 1'b0;
      stuck_lo <= 1'b0;
    end else if (!en) begin
      r_state  <= ARM;
      r_hiCnt  <= '0;
      r_perCnt <= '0;
      r_armCnt <= '0;
      valid    <= 1'b0;
      stuck_hi <= 1'b0;
      stuck_lo <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        ARM: begin
          r_hiCnt  <= '0;
          r_perCnt <= '0;
          if (w_rise) begin
            r_hiCnt  <= {{(CW-1){1'b0}}, 1'b1};
            r_perCnt <= {{(CW-1){1'b0}}, 1'b1};
            r_armCnt <= '0;
            r_state  <= HIGH;
          end else if (w_fall) begin
            r_armCnt <= '0;
          end else begin
            // No edge while armed: a line that never toggles is still reported as stuck.
            r_armCnt <= w_armNext;
            if (r_armCnt >= c_timeout) begin
              if (w_pwmS) begin
                stuck_hi <= 1'b1;
              end else begin
                stuck_lo <= 1'b1;
              end
            end
          end
        end

        HIGH, LOW: begin
          if (w_rise) begin
            // Edge cycle is the first high cycle of the new period.
            if (w_outValid) begin
              duty     <= w_outDuty;
              period   <= w_outPer;
              valid    <= 1'b1;
            end
            stuck_hi <= 1'b0;
            stuck_lo <= 1'b0;
            r_hiCnt  <= {{(CW-1){1'b0}}, 1'b1};
            r_perCnt <= {{(CW-1){1'b0}}, 1'b1};
            r_state  <= HIGH;
          end else if (r_perCnt >= c_timeout) begin
            if (r_state == HIGH) begin
              stuck_hi <= 1'b1;
            end else begin
              stuck_lo <= 1'b1;
            end
            r_hiCnt  <= '0;
            r_perCnt <= '0;
            r_armCnt <= '0;
            r_state  <= ARM;
          end else if (r_state == HIGH && !w_fall) begin
            r_hiCnt  <= w_hiNext;
            r_perCnt <= w_perNext;
          end else begin
            // Falling-edge cycle already counts as low time.
            r_perCnt <= w_perNext;
            r_state  <= LOW;
          end
        end

        default: begin
          r_hiCnt  <= '0;
          r_perCnt <= '0;
          r_armCnt <= '0;
          r_state  <= ARM;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
